// File: rtl/cache_trace_player.sv
// Replays a stored address trace into a direct-mapped cache and accumulates hit/miss statistics.
// Optional miss-run tracker compiled in with `define CACHE_TRACE_PLAYER_RUNSTAT_EN.
module cache_trace_player #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [ADDR_W-1:0] load_data,
  input  logic              start,
  input  logic [IDX_W:0]    count,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  miss_run_max
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [3:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    hits_q, hits_d;
  logic [CNT_W-1:0]    misses_q, misses_d;
  logic [ADDR_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem [DEPTH];

  logic startAccept;
  assign startAccept = (state_q == S_IDLE) && start;

  // Trace RAM: writes only while idle, so a read and write never collide.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && load_en) mem[load_idx] <= load_data;
    if (state_q == S_FETCH) rdata_q <= mem[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d  = (count > DEPTH_C) ? DEPTH_C : count;
          hits_d   = '0;
          misses_d = '0;
          idx_d    = '0;
          state_d  = S_FETCH;
        end
      end
      // An empty run spends its single fetch slot and then reports done.
      S_FETCH: state_d = (count_q == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        addr_d  = rdata_q;
        wait_d  = SETTLE_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_SAMPLE;
        else              wait_d  = wait_q - 4'd1;
      end
      S_SAMPLE: begin
        if (cache_hit) hits_d   = (hits_q == CNT_MAX) ? hits_q : hits_q + 1'b1;
        else           misses_d = (misses_q == CNT_MAX) ? misses_q : misses_q + 1'b1;
        if ({1'b0, idx_q} + (IDX_W+1)'(1) == count_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

`ifdef CACHE_TRACE_PLAYER_RUNSTAT_EN
  logic [CNT_W-1:0] run_q, run_d, runMax_q, runMax_d;

  // Current run of consecutive misses and the longest seen this replay.
  always_comb begin
    run_d    = run_q;
    runMax_d = runMax_q;
    if (startAccept) begin
      run_d    = '0;
      runMax_d = '0;
    end else if (state_q == S_SAMPLE) begin
      if (cache_hit) begin
        run_d = '0;
      end else begin
        run_d = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
        if (run_d > runMax_q) runMax_d = run_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= '0;
      runMax_q <= '0;
    end else begin
      run_q    <= run_d;
      runMax_q <= runMax_d;
    end
  end

  assign miss_run_max = runMax_q;
`else
  assign miss_run_max = '0;
`endif

  assign cache_addr = addr_q;
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_cache_trace_player.sv
// Self-checking bench for cache_trace_player: random traces against a direct-mapped cache model,
// plus a second instance with 3-bit counters for saturation.
module tb_cache_trace_player;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int SETTLE = 1;
  localparam int P      = 3 + SETTLE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [IDX_W-1:0]  load_idx;
  logic [ADDR_W-1:0] load_data;
  logic              start;
  logic [IDX_W:0]    count;
  logic              cacheHit;

  logic [ADDR_W-1:0] cacheAddr, satCacheAddr;
  logic              busy, done, satBusy, satDone;
  logic [31:0]       hits, misses, mrm;
  logic [2:0]        satHits, satMisses, satMrm;

  int checks = 0;
  int passes = 0;

  logic [31:0] trace [DEPTH];
  bit          hitVec [DEPTH];

  always #5 clk = ~clk;

  cache_trace_player #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .SETTLE(SETTLE), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .start(start), .count(count), .cache_addr(cacheAddr), .cache_hit(cacheHit),
    .busy(busy), .done(done), .hits(hits), .misses(misses), .miss_run_max(mrm)
  );

  cache_trace_player #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .SETTLE(SETTLE), .CNT_W(3)) satDut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .start(start), .count(count), .cache_addr(satCacheAddr), .cache_hit(cacheHit),
    .busy(satBusy), .done(satDone), .hits(satHits), .misses(satMisses), .miss_run_max(satMrm)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Writes trace[0..n-1] into both players' RAMs.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_idx  = IDX_W'(i);
      load_data = trace[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Direct-mapped reference cache: 16 lines of 4 bytes, starts empty.
  task automatic modelCache(input int n);
    logic [25:0] tags [16];
    bit          valid [16];
    logic [3:0]  line;
    for (int i = 0; i < 16; i++) valid[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      line      = trace[k][5:2];
      hitVec[k] = valid[line] && (tags[line] == trace[k][31:6]);
      valid[line] = 1'b1;
      tags[line]  = trace[k][31:6];
    end
  endtask

  task automatic expectStats(input int n, input longint lim, output longint h, output longint m, output longint mx);
    longint r;
    h = 0; m = 0; r = 0; mx = 0;
    for (int k = 0; k < n; k++) begin
      if (hitVec[k]) begin
        if (h < lim) h++;
        r = 0;
      end else begin
        if (m < lim) m++;
        if (r < lim) r++;
        if (r > mx) mx = r;
      end
    end
  endtask

  function automatic logic [31:0] randomAddr();
    logic [31:0] a;
    a = 32'h4000_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  // Replays n entries (count input reqCount) and checks timing, address sequence and statistics.
  task automatic runReplay(input int n, input int reqCount, input bit abuse, input string tag);
    longint eh, em, emx, sh, sm, smx;
    int doneEdge, k;
    bit early;
    expectStats(n, 64'hFFFF_FFFF, eh, em, emx);
    expectStats(n, 7, sh, sm, smx);
`ifndef CACHE_TRACE_PLAYER_RUNSTAT_EN
    emx = 0;
    smx = 0;
`endif
    doneEdge = (n == 0) ? 1 : n * P;
    early = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    count    = (IDX_W+1)'(reqCount);
    cacheHit = (n > 0) ? hitVec[0] : 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".busy"}, busy, 1);
    for (int e = 0; e <= doneEdge + 1; e++) begin
      k = e / P;
      if (k < n) cacheHit = hitVec[k];
      if (k < n && e % P == 2) checkOutput({tag, ".addr"}, cacheAddr, trace[k]);
      if (e < doneEdge && (done || satDone)) early = 1'b1;
      if (e == doneEdge) begin
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".satDone"}, satDone, 1);
        checkOutput({tag, ".busyAtDone"}, busy, 0);
      end
      if (abuse && e == 3) begin
        start = 1'b1; count = 7'd2;
        load_en = 1'b1; load_idx = '0; load_data = 32'hDEAD_BEEF;
      end else if (abuse && e == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
      if (e == doneEdge + 1) begin
        checkOutput({tag, ".doneEnd"}, done, 0);
        checkOutput({tag, ".busyEnd"}, busy, 0);
        checkOutput({tag, ".satBusyEnd"}, satBusy, 0);
        checkOutput({tag, ".earlyDone"}, early, 0);
        checkOutput({tag, ".hits"}, hits, eh);
        checkOutput({tag, ".misses"}, misses, em);
        checkOutput({tag, ".missRunMax"}, mrm, emx);
        checkOutput({tag, ".satHits"}, satHits, sh);
        checkOutput({tag, ".satMisses"}, satMisses, sm);
        checkOutput({tag, ".satMissRunMax"}, satMrm, smx);
        if (n > 0) checkOutput({tag, ".addrHold"}, satCacheAddr, trace[n-1]);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] basicTrace [5];
    int n;
    bit sawDone;
    basicTrace = '{32'h14, 32'h14, 32'h216, 32'h16, 32'h217};
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;
    count = '0; cacheHit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.addr", cacheAddr, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.hits", hits, 0);
    checkOutput("reset.misses", misses, 0);
    checkOutput("reset.missRunMax", mrm, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) trace[i] = basicTrace[i];
    applyStimulus(5);
    modelCache(5);
    runReplay(5, 5, 0, "basic");

    runReplay(0, 0, 0, "empty");

    for (int i = 0; i < 7; i++) trace[i] = randomAddr();
    applyStimulus(7);
    hitVec[0] = 0; hitVec[1] = 0; hitVec[2] = 1; hitVec[3] = 0;
    hitVec[4] = 0; hitVec[5] = 0; hitVec[6] = 1;
    runReplay(7, 7, 0, "missRuns");

    for (int i = 0; i < 10; i++) begin
      trace[i]  = randomAddr();
      hitVec[i] = 1'b1;
    end
    applyStimulus(10);
    runReplay(10, 10, 0, "saturate");
    checkOutput("saturate.satHitsCap", satHits, 7);

    for (int i = 0; i < 4; i++) trace[i] = randomAddr();
    applyStimulus(4);
    modelCache(4);
    runReplay(4, 4, 1, "abuse");
    runReplay(4, 4, 0, "readback");

    for (int i = 0; i < DEPTH; i++) trace[i] = randomAddr();
    applyStimulus(DEPTH);
    modelCache(DEPTH);
    runReplay(DEPTH, 100, 0, "clamp");

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) trace[i] = randomAddr();
      applyStimulus(n);
      if (it % 2 == 0) modelCache(n);
      else for (int i = 0; i < n; i++) hitVec[i] = 1'($urandom_range(0, 1));
      runReplay(n, n, 0, "random");
    end

    for (int i = 0; i < 5; i++) trace[i] = randomAddr();
    applyStimulus(5);
    modelCache(5);
    @(negedge clk);
    start = 1'b1; count = 7'd5; cacheHit = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midReset.addr", cacheAddr, 0);
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.done", done, 0);
    checkOutput("midReset.hits", hits, 0);
    checkOutput("midReset.misses", misses, 0);
    checkOutput("midReset.missRunMax", mrm, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", sawDone, 0);
    runReplay(5, 5, 0, "postReset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
